syncram_tdp: RTL and testbench

SYNCRAM_TDP -- requirements
Module: syncram_tdp

---
 rtl/syncram_tdp.sv | 177 +++++++++++++++++
 tb/tb_syncram_tdp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syncram_tdp.sv
// True dual-port synchronous RAM: byte-lane writes, selectable read-during-write behaviour,
// optional output register stage and a post-reset zero-fill engine.
module syncram_tdp #(
    parameter int    WIDTH          = 16,
    parameter int    NUMWORDS       = 256,
    parameter int    WIDTHAD        = $clog2(NUMWORDS),
    parameter int    BYTE_SIZE      = 8,
    parameter string OUTDATA_REG    = "UNREGISTERED",
    parameter string RDW_MODE_A     = "OLD_DATA",
    parameter string RDW_MODE_B     = "OLD_DATA",
    parameter string RDW_MODE_MIXED = "OLD_DATA",
    parameter int    CLEAR_ON_RESET = 1,
    localparam int   WIDTH_BE       = (WIDTH + BYTE_SIZE - 1) / BYTE_SIZE
) (
    input  logic                clock0,
    input  logic                aclr0_n,
    input  logic                clocken0,
    output logic                busy,
    input  logic [WIDTHAD-1:0]  address_a,
    input  logic [WIDTH_BE-1:0] byteena_a,
    input  logic                addressstall_a,
    input  logic                wren_a,
    input  logic                rden_a,
    input  logic [WIDTH-1:0]    data_a,
    output logic [WIDTH-1:0]    q_a,
    output logic                rvalid_a,
    input  logic [WIDTHAD-1:0]  address_b,
    input  logic [WIDTH_BE-1:0] byteena_b,
    input  logic                addressstall_b,
    input  logic                wren_b,
    input  logic                rden_b,
    input  logic [WIDTH-1:0]    data_b,
    output logic [WIDTH-1:0]    q_b,
    output logic                rvalid_b,
    output logic                collision
);

    localparam bit NEW_A     = (RDW_MODE_A == "NEW_DATA");
    localparam bit NEW_B     = (RDW_MODE_B == "NEW_DATA");
    localparam bit NEW_MIXED = (RDW_MODE_MIXED == "NEW_DATA");
    localparam logic [WIDTHAD-1:0] LAST_ADDR = WIDTHAD'(NUMWORDS - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} fill_state_e;

    logic [WIDTH-1:0]   mem [NUMWORDS];
    fill_state_e        state_q;
    logic [WIDTHAD-1:0] fill_addr_q;
    logic               busy_q;

    logic [WIDTHAD-1:0] areg_a_q, areg_b_q, ea_a, ea_b;
    logic [WIDTH-1:0]   mask_a, mask_b, old_a, old_b, wr_word_a, wr_word_b, rdata_a, rdata_b;
    logic               en, inr_a, inr_b, we_a, we_b, re_a, re_b, collide;
    logic               rv1_a_q, rv1_b_q;
    logic [WIDTH-1:0]   rd1_a_q, rd1_b_q;

    // Zero-fill engine; runs regardless of clocken0.
    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StFill : StDone;
            busy_q      <= (CLEAR_ON_RESET != 0);
            fill_addr_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q     <= (CLEAR_ON_RESET != 0) ? StFill : StDone;
                    busy_q      <= (CLEAR_ON_RESET != 0);
                    fill_addr_q <= '0;
                end
                StFill: begin
                    if (fill_addr_q == LAST_ADDR) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                    end else begin
                        fill_addr_q <= fill_addr_q + 1'b1;
                    end
                end
                StDone:  ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign mask_a[i] = byteena_a[i / BYTE_SIZE];
        assign mask_b[i] = byteena_b[i / BYTE_SIZE];
    end

    assign en      = clocken0 & ~busy_q;
    assign ea_a    = addressstall_a ? areg_a_q : address_a;
    assign ea_b    = addressstall_b ? areg_b_q : address_b;
    assign inr_a   = 32'(ea_a) < NUMWORDS;
    assign inr_b   = 32'(ea_b) < NUMWORDS;
    assign old_a   = inr_a ? mem[ea_a] : '0;
    assign old_b   = inr_b ? mem[ea_b] : '0;
    assign we_a    = en & wren_a & inr_a;
    assign we_b    = en & wren_b & inr_b;
    assign re_a    = en & rden_a;
    assign re_b    = en & rden_b;
    assign collide = we_a & we_b & (ea_a == ea_b);

    // On a write-write conflict port A carries the fully merged word; port B's write is dropped.
    assign wr_word_a = (data_a & mask_a) |
                       (collide ? ((data_b & mask_b & ~mask_a) | (old_a & ~(mask_a | mask_b)))
                                : (old_a & ~mask_a));
    assign wr_word_b = (data_b & mask_b) | (old_b & ~mask_b);

    always_comb begin
        rdata_a = old_a;
        if (we_a) begin
            if (NEW_A) rdata_a = wr_word_a;
        end else if (we_b && (ea_b == ea_a)) begin
            if (NEW_MIXED) rdata_a = wr_word_b;
        end
    end

    always_comb begin
        rdata_b = old_b;
        if (we_b) begin
            if (NEW_B) rdata_b = collide ? wr_word_a : wr_word_b;
        end else if (we_a && (ea_a == ea_b)) begin
            if (NEW_MIXED) rdata_b = wr_word_a;
        end
    end

    always_ff @(posedge clock0) begin
        if (busy_q) begin
            mem[fill_addr_q] <= '0;
        end else if (aclr0_n) begin
            if (we_b && !collide) mem[ea_b] <= wr_word_b;
            if (we_a)             mem[ea_a] <= wr_word_a;
        end
    end

    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            areg_a_q  <= '0;
            areg_b_q  <= '0;
            collision <= 1'b0;
            rv1_a_q   <= 1'b0;
            rv1_b_q   <= 1'b0;
            rd1_a_q   <= '0;
            rd1_b_q   <= '0;
        end else if (clocken0) begin
            if (!addressstall_a) areg_a_q <= address_a;
            if (!addressstall_b) areg_b_q <= address_b;
            collision <= collide;
            rv1_a_q   <= re_a;
            rv1_b_q   <= re_b;
            if (re_a) rd1_a_q <= rdata_a;
            if (re_b) rd1_b_q <= rdata_b;
        end
    end

    if (OUTDATA_REG == "CLOCK0") begin : g_outreg
        always_ff @(posedge clock0 or negedge aclr0_n) begin
            if (!aclr0_n) begin
                rvalid_a <= 1'b0;
                rvalid_b <= 1'b0;
                q_a      <= '0;
                q_b      <= '0;
            end else if (clocken0) begin
                rvalid_a <= rv1_a_q;
                rvalid_b <= rv1_b_q;
                if (rv1_a_q) q_a <= rd1_a_q;
                if (rv1_b_q) q_b <= rd1_b_q;
            end
        end
    end else begin : g_outdirect
        assign rvalid_a = rv1_a_q;
        assign rvalid_b = rv1_b_q;
        assign q_a      = rd1_a_q;
        assign q_b      = rd1_b_q;
    end

endmodule

// File: tb/tb_syncram_tdp.sv
// Bench for syncram_tdp: two configurations driven in lockstep, checked against a word-level
// reference model every cycle, plus a directed vector table for the 16-bit instance.
module tb_syncram_tdp;

    logic clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    logic        aclr0_n, clocken0;
    logic [2:0]  address_a, address_b, byteena_a, byteena_b;
    logic        addressstall_a, addressstall_b, wren_a, wren_b, rden_a, rden_b;
    logic [19:0] data_a, data_b;
    logic        busy0, busy1, coll0, coll1, rv_a0, rv_b0, rv_a1, rv_b1;
    logic [15:0] q_a0, q_b0;
    logic [19:0] q_a1, q_b1;

    // 16-bit, 8 words, unregistered output, OLD_DATA everywhere
    syncram_tdp #(
        .WIDTH(16), .NUMWORDS(8), .WIDTHAD(3), .BYTE_SIZE(8)
    ) dut0 (
        .clock0(clock0), .aclr0_n(aclr0_n), .clocken0(clocken0), .busy(busy0),
        .address_a(address_a), .byteena_a(byteena_a[1:0]), .addressstall_a(addressstall_a),
        .wren_a(wren_a), .rden_a(rden_a), .data_a(data_a[15:0]), .q_a(q_a0), .rvalid_a(rv_a0),
        .address_b(address_b), .byteena_b(byteena_b[1:0]), .addressstall_b(addressstall_b),
        .wren_b(wren_b), .rden_b(rden_b), .data_b(data_b[15:0]), .q_b(q_b0), .rvalid_b(rv_b0),
        .collision(coll0)
    );

    // 20-bit (partial top lane), 6 words so addresses 6/7 are out of range, registered, NEW_DATA
    syncram_tdp #(
        .WIDTH(20), .NUMWORDS(6), .WIDTHAD(3), .BYTE_SIZE(8), .OUTDATA_REG("CLOCK0"),
        .RDW_MODE_A("NEW_DATA"), .RDW_MODE_B("NEW_DATA"), .RDW_MODE_MIXED("NEW_DATA")
    ) dut1 (
        .clock0(clock0), .aclr0_n(aclr0_n), .clocken0(clocken0), .busy(busy1),
        .address_a(address_a), .byteena_a(byteena_a), .addressstall_a(addressstall_a),
        .wren_a(wren_a), .rden_a(rden_a), .data_a(data_a), .q_a(q_a1), .rvalid_a(rv_a1),
        .address_b(address_b), .byteena_b(byteena_b), .addressstall_b(addressstall_b),
        .wren_b(wren_b), .rden_b(rden_b), .data_b(data_b), .q_b(q_b1), .rvalid_b(rv_b1),
        .collision(coll1)
    );

    int unsigned cfg_w [2] = '{16, 20};
    int unsigned cfg_n [2] = '{8, 6};
    int unsigned cfg_l [2] = '{1, 2};
    bit          cfg_nd[2] = '{1'b0, 1'b1};

    int unsigned m_mem  [2][8];
    int unsigned m_fill [2];
    int unsigned m_areg [2][2];
    bit          m_pv   [2][2][2];
    int unsigned m_pd   [2][2][2];
    bit          m_rv   [2][2];
    int unsigned m_q    [2][2];
    bit          m_coll [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Word at tgt after this edge: lanes enabled on A win, then lanes enabled on B.
    function automatic int unsigned final_word(input int d, input int unsigned tgt,
                                               input int unsigned ea0, input int unsigned ea1,
                                               input bit wv0, input bit wv1,
                                               input logic [2:0] be0, input logic [2:0] be1,
                                               input int unsigned d0, input int unsigned d1);
        int unsigned w;
        w = m_mem[d][tgt];
        for (int b = 0; b < int'(cfg_w[d]); b++) begin
            if (wv0 && ea0 == tgt && be0[b / 8])      w[b] = d0[b];
            else if (wv1 && ea1 == tgt && be1[b / 8]) w[b] = d1[b];
        end
        return w;
    endfunction

    task automatic model_edge(input int d);
        int unsigned ad [2], dat [2], ea [2], oldw [2], neww [2], rd_val [2];
        logic [2:0]  be [2];
        bit          st [2], wr [2], rd [2], inr [2], wv [2];
        bit          busy_now, en;
        int unsigned lat;
        ad[0] = address_a;  ad[1] = address_b;
        be[0] = byteena_a;  be[1] = byteena_b;
        st[0] = addressstall_a; st[1] = addressstall_b;
        wr[0] = wren_a;     wr[1] = wren_b;
        rd[0] = rden_a;     rd[1] = rden_b;
        dat[0] = data_a & ((1 << cfg_w[d]) - 1);
        dat[1] = data_b & ((1 << cfg_w[d]) - 1);
        busy_now = (m_fill[d] != 0);
        if (busy_now) begin
            m_mem[d][cfg_n[d] - m_fill[d]] = 0;
            m_fill[d]--;
        end
        en = clocken0 && !busy_now;
        for (int p = 0; p < 2; p++) begin
            ea[p]  = st[p] ? m_areg[d][p] : ad[p];
            inr[p] = ea[p] < cfg_n[d];
            wv[p]  = en && wr[p] && inr[p];
        end
        for (int p = 0; p < 2; p++) begin
            oldw[p] = inr[p] ? m_mem[d][ea[p]] : 0;
            neww[p] = inr[p] ? final_word(d, ea[p], ea[0], ea[1], wv[0], wv[1], be[0], be[1],
                                          dat[0], dat[1]) : 0;
        end
        for (int p = 0; p < 2; p++) begin
            bit hit;
            hit = wv[p] || (wv[1 - p] && ea[1 - p] == ea[p]);
            rd_val[p] = (hit && cfg_nd[d]) ? neww[p] : oldw[p];
        end
        if (wv[0]) m_mem[d][ea[0]] = neww[0];
        if (wv[1]) m_mem[d][ea[1]] = neww[1];
        if (clocken0) begin
            lat = cfg_l[d];
            for (int p = 0; p < 2; p++) begin
                m_pv[d][p][1] = m_pv[d][p][0];
                m_pd[d][p][1] = m_pd[d][p][0];
                m_pv[d][p][0] = en && rd[p];
                m_pd[d][p][0] = rd_val[p];
                m_rv[d][p]    = m_pv[d][p][lat - 1];
                if (m_rv[d][p]) m_q[d][p] = m_pd[d][p][lat - 1];
                if (!st[p]) m_areg[d][p] = ad[p];
            end
            m_coll[d] = wv[0] && wv[1] && ea[0] == ea[1];
        end
    endtask

    task automatic compare_all();
        check("busy0", busy0, m_fill[0] != 0);
        check("busy1", busy1, m_fill[1] != 0);
        check("coll0", coll0, m_coll[0]);
        check("coll1", coll1, m_coll[1]);
        check("rvalid_a0", rv_a0, m_rv[0][0]);
        check("rvalid_b0", rv_b0, m_rv[0][1]);
        check("rvalid_a1", rv_a1, m_rv[1][0]);
        check("rvalid_b1", rv_b1, m_rv[1][1]);
        check("q_a0", q_a0, m_q[0][0]);
        check("q_b0", q_b0, m_q[0][1]);
        check("q_a1", q_a1, m_q[1][0]);
        check("q_b1", q_b1, m_q[1][1]);
    endtask

    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clock0);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        clocken0 = 1'b1;
        address_a = '0; address_b = '0; byteena_a = '0; byteena_b = '0;
        addressstall_a = 1'b0; addressstall_b = 1'b0;
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        data_a = '0; data_b = '0;
    endtask

    // Asserts reset away from a clock edge, checks the immediate clear, releases before an edge.
    task automatic apply_reset();
        aclr0_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            m_fill[d] = cfg_n[d];
            m_coll[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_areg[d][p] = 0;
                m_rv[d][p]   = 1'b0;
                m_q[d][p]    = 0;
                for (int s = 0; s < 2; s++) begin
                    m_pv[d][p][s] = 1'b0;
                    m_pd[d][p][s] = 0;
                end
            end
        end
        compare_all();
        @(posedge clock0);
        @(posedge clock0);
        #3;
        aclr0_n = 1'b1;
    endtask

    task automatic count_fill();
        int n0, n1, iter;
        n0 = 0; n1 = 0; iter = 0;
        while ((busy0 || busy1) && iter < 20) begin
            if (busy0) n0++;
            if (busy1) n1++;
            cycle();
            iter++;
        end
        check("fill_len0", n0, 8);
        check("fill_len1", n1, 6);
    endtask

    typedef struct {
        bit          ce, sa, wa, wb, ra, rb;
        logic [2:0]  aa, ab;
        logic [1:0]  bea, beb;
        logic [15:0] da, db;
        bit          xrva, xrvb, xcoll;
        logic [15:0] xqa, xqb;
    } vec_t;

    vec_t vecs [19];

    initial begin
        //            ce sa wa wb ra rb aa ab bea    beb    da        db      rva rvb col qa  qb
        vecs[0]  = '{1, 0, 1, 0, 0, 0, 3, 0, 2'b11, 2'b00, 16'h1111, 16'h0, 0, 0, 0, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 0, 1, 0, 0, 0, 3, 0, 2'b01, 2'b00, 16'hABCD, 16'h0, 0, 0, 0, 16'h0000, 16'h0000};
        vecs[2]  = '{1, 0, 0, 0, 0, 1, 0, 3, 2'b00, 2'b00, 16'h0000, 16'h0, 0, 1, 0, 16'h0000, 16'h11CD};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 16'h11CD};
        vecs[4]  = '{1, 0, 1, 0, 1, 0, 5, 0, 2'b11, 2'b00, 16'h1234, 16'h0, 1, 0, 0, 16'h0000, 16'h11CD};
        vecs[5]  = '{1, 0, 0, 0, 1, 0, 5, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'h1234, 16'h11CD};
        vecs[6]  = '{1, 0, 1, 1, 0, 0, 2, 2, 2'b11, 2'b11, 16'hAAAA, 16'h5555, 0, 0, 1, 16'h1234, 16'h11CD};
        vecs[7]  = '{1, 0, 0, 0, 1, 0, 2, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'hAAAA, 16'h11CD};
        vecs[8]  = '{1, 0, 1, 1, 0, 1, 1, 1, 2'b01, 2'b10, 16'h00AA, 16'hBB00, 0, 1, 1, 16'hAAAA, 16'h0000};
        vecs[9]  = '{1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'hBBAA, 16'h0000};
        vecs[10] = '{1, 0, 1, 1, 0, 0, 6, 4, 2'b11, 2'b11, 16'h6666, 16'h4444, 0, 0, 0, 16'hBBAA, 16'h0000};
        vecs[11] = '{1, 0, 0, 0, 1, 0, 4, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'h4444, 16'h0000};
        vecs[12] = '{1, 1, 1, 0, 1, 0, 6, 0, 2'b11, 2'b00, 16'h7777, 16'h0, 1, 0, 0, 16'h4444, 16'h0000};
        vecs[13] = '{1, 1, 0, 0, 1, 0, 6, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'h7777, 16'h0000};
        vecs[14] = '{0, 0, 1, 0, 1, 0, 0, 0, 2'b11, 2'b00, 16'h9999, 16'h0, 1, 0, 0, 16'h7777, 16'h0000};
        vecs[15] = '{0, 0, 1, 0, 1, 0, 0, 0, 2'b11, 2'b00, 16'h9999, 16'h0, 1, 0, 0, 16'h7777, 16'h0000};
        vecs[16] = '{0, 0, 1, 0, 1, 0, 0, 0, 2'b11, 2'b00, 16'h9999, 16'h0, 1, 0, 0, 16'h7777, 16'h0000};
        vecs[17] = '{1, 0, 0, 0, 1, 0, 6, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'h6666, 16'h0000};
        vecs[18] = '{1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 16'h0, 1, 0, 0, 16'h0000, 16'h0000};

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 8; a++) m_mem[d][a] = 0;
        idle_inputs();
        aclr0_n = 1'b1;
        #1;

        // Reset, interrupt the fill part-way, and confirm it restarts from the beginning.
        apply_reset();
        for (int i = 0; i < 3; i++) cycle();
        apply_reset();
        count_fill();

        // Every word reads back as zero after the fill (dut1 addresses 6/7 are out of range).
        for (int a = 0; a < 8; a++) begin
            address_a = 3'(a); rden_a = 1'b1;
            address_b = 3'(7 - a); rden_b = 1'b1;
            cycle();
        end
        idle_inputs();
        cycle();

        // Partial top lane on the 20-bit instance.
        wren_a = 1'b1; address_a = 3'd0; byteena_a = 3'b100; data_a = 20'hFFFFF;
        cycle();
        idle_inputs();
        rden_a = 1'b1; address_a = 3'd0;
        cycle();
        idle_inputs();
        cycle();
        check("top_lane_q_a1", q_a1, 32'h000F0000);
        check("top_lane_rvalid_a1", rv_a1, 1);

        for (int i = 0; i < 19; i++) begin
            clocken0 = vecs[i].ce;
            addressstall_a = vecs[i].sa; addressstall_b = 1'b0;
            wren_a = vecs[i].wa; wren_b = vecs[i].wb;
            rden_a = vecs[i].ra; rden_b = vecs[i].rb;
            address_a = vecs[i].aa; address_b = vecs[i].ab;
            byteena_a = {1'b0, vecs[i].bea}; byteena_b = {1'b0, vecs[i].beb};
            data_a = {4'h0, vecs[i].da}; data_b = {4'h0, vecs[i].db};
            cycle();
            check($sformatf("vec%0d_rvalid_a", i), rv_a0, vecs[i].xrva);
            check($sformatf("vec%0d_rvalid_b", i), rv_b0, vecs[i].xrvb);
            check($sformatf("vec%0d_collision", i), coll0, vecs[i].xcoll);
            check($sformatf("vec%0d_q_a", i), q_a0, vecs[i].xqa);
            check($sformatf("vec%0d_q_b", i), q_b0, vecs[i].xqb);
        end
        idle_inputs();

        for (int i = 0; i < 400; i++) begin
            clocken0       = ($urandom_range(0, 7) != 0);
            address_a      = 3'($urandom);
            address_b      = 3'($urandom);
            addressstall_a = ($urandom_range(0, 3) == 0);
            addressstall_b = ($urandom_range(0, 3) == 0);
            wren_a         = 1'($urandom);
            wren_b         = 1'($urandom);
            rden_a         = 1'($urandom);
            rden_b         = 1'($urandom);
            byteena_a      = 3'($urandom);
            byteena_b      = 3'($urandom);
            data_a         = 20'($urandom);
            data_b         = 20'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
